// File: rtl/trap_pkg.sv
// rtl/trap_pkg.sv - trap controller CSR addresses, FSM states and cause codes
// R_MEPC only exists when TRAP_MRET_EN is defined.
package trap_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;

  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd1;
  localparam logic [31:0] CAUSE_DIV_ZERO   = 32'd2;
  localparam logic [31:0] CAUSE_MEM_ERR    = 32'd3;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MTVAL,
    R_MTVEC,
`ifdef TRAP_MRET_EN
    R_MEPC,
`endif
    REDIRECT
  } trap_state_e;

  function automatic logic [31:0] csr_addr(input logic [11:0] a);
    return {20'd0, a};
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap entry/return sequencer driving mepc/mcause/mtval writes and PC redirect
// Optional mret return path enabled by defining TRAP_MRET_EN.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter logic [31:0] FALLBACK_TVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        exc_valid,
  output logic        exc_ready,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_cause,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  output logic [31:0] csr_address,
  output logic [31:0] csr_din,
  output logic        csr_we,
  input  logic [31:0] csr_dout,
  output logic        busy,
  output logic        redir_valid,
  output logic [31:0] redir_target
);

  trap_state_e state;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] tval_q;
  logic [31:0] mtvec_target;

  always_comb begin
    mtvec_target = (csr_dout == 32'd0) ? FALLBACK_TVEC : (csr_dout & 32'hFFFF_FFFC);
  end

`ifdef TRAP_MRET_EN
  logic mepc_wait;
`else
  logic unused_mret;
  assign unused_mret = mret_valid;
`endif

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      pc_q         <= '0;
      cause_q      <= '0;
      tval_q       <= '0;
      exc_ready    <= 1'b1;
      busy         <= 1'b0;
      redir_valid  <= 1'b0;
      redir_target <= '0;
      csr_we       <= 1'b0;
      csr_address  <= '0;
      csr_din      <= '0;
`ifdef TRAP_MRET_EN
      mepc_wait    <= 1'b0;
`endif
    end else begin
      csr_we       <= 1'b0;
      csr_address  <= '0;
      csr_din      <= '0;
      redir_valid  <= 1'b0;
      redir_target <= '0;
      exc_ready    <= 1'b0;
      busy         <= 1'b1;
      case (state)
        IDLE: begin
          if (exc_valid) begin
            pc_q        <= exc_pc;
            cause_q     <= exc_cause;
            tval_q      <= exc_tval;
            state       <= W_MEPC;
            csr_address <= csr_addr(CSR_MEPC);
            csr_din     <= exc_pc;
            csr_we      <= 1'b1;
`ifdef TRAP_MRET_EN
          end else if (mret_valid) begin
            state       <= R_MEPC;
            mepc_wait   <= 1'b1;
            csr_address <= csr_addr(CSR_MEPC);
`endif
          end else begin
            exc_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        W_MEPC: begin
          state       <= W_MCAUSE;
          csr_address <= csr_addr(CSR_MCAUSE);
          csr_din     <= cause_q;
          csr_we      <= 1'b1;
        end
        W_MCAUSE: begin
          state       <= W_MTVAL;
          csr_address <= csr_addr(CSR_MTVAL);
          csr_din     <= tval_q;
          csr_we      <= 1'b1;
        end
        W_MTVAL: begin
          state       <= R_MTVEC;
          csr_address <= csr_addr(CSR_MTVEC);
        end
        R_MTVEC: begin
          state        <= REDIRECT;
          redir_valid  <= 1'b1;
          redir_target <= mtvec_target;
        end
`ifdef TRAP_MRET_EN
        // mepc is presented for two cycles so the return redirect lands two cycles after the pulse.
        R_MEPC: begin
          if (mepc_wait) begin
            mepc_wait   <= 1'b0;
            csr_address <= csr_addr(CSR_MEPC);
          end else begin
            state        <= REDIRECT;
            redir_valid  <= 1'b1;
            redir_target <= csr_dout & 32'hFFFF_FFFC;
          end
        end
`endif
        REDIRECT: begin
          state     <= IDLE;
          exc_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          exc_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
// Exercises the mret path when TRAP_MRET_EN is defined.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        exc_valid = 1'b0;
  logic        exc_ready;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_cause = '0;
  logic [31:0] exc_tval = '0;
  logic        mret_valid = 1'b0;
  logic [31:0] csr_address;
  logic [31:0] csr_din;
  logic        csr_we;
  logic [31:0] csr_dout;
  logic        busy;
  logic        redir_valid;
  logic [31:0] redir_target;

  logic [31:0] mtvec_val = '0;
  logic [31:0] mepc_val = '0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign csr_dout = (csr_address == 32'h305) ? mtvec_val :
                    (csr_address == 32'h341) ? mepc_val : 32'd0;

  trap_ctrl #(.FALLBACK_TVEC(32'h80)) dut (
    .clk(clk), .rstn(rstn),
    .exc_valid(exc_valid), .exc_ready(exc_ready),
    .exc_pc(exc_pc), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .mret_valid(mret_valid),
    .csr_address(csr_address), .csr_din(csr_din), .csr_we(csr_we), .csr_dout(csr_dout),
    .busy(busy), .redir_valid(redir_valid), .redir_target(redir_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_exc(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval,
                         input logic [31:0] mtvec, input logic [31:0] exp_tgt, input logic mret_hold);
    exc_pc = pc; exc_cause = cause; exc_tval = tval; mtvec_val = mtvec;
    exc_valid = 1'b1; mret_valid = mret_hold;
    tick();
    exc_valid = 1'b0;
    exc_pc = ~pc; exc_cause = ~cause; exc_tval = ~tval;
    check("mepc_addr", csr_address, 32'h341);
    check("mepc_din", csr_din, pc);
    check("mepc_we", csr_we, 1);
    check("mepc_ready", exc_ready, 0);
    check("mepc_busy", busy, 1);
    tick();
    check("mcause_addr", csr_address, 32'h342);
    check("mcause_din", csr_din, cause);
    check("mcause_we", csr_we, 1);
    tick();
    check("mtval_addr", csr_address, 32'h343);
    check("mtval_din", csr_din, tval);
    check("mtval_we", csr_we, 1);
    tick();
    check("mtvec_addr", csr_address, 32'h305);
    check("mtvec_we", csr_we, 0);
    check("mtvec_redir", redir_valid, 0);
    tick();
    check("redir_valid", redir_valid, 1);
    check("redir_target", redir_target, exp_tgt);
    check("redir_addr", csr_address, 0);
    check("redir_we", csr_we, 0);
    check("redir_ready", exc_ready, 0);
    mret_valid = 1'b0;
    tick();
    check("done_ready", exc_ready, 1);
    check("done_busy", busy, 0);
    check("done_redir", redir_valid, 0);
  endtask

  initial begin
    logic saw;
    tick();
    check("rst_ready", exc_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_redir", redir_valid, 0);
    check("rst_target", redir_target, 0);
    check("rst_we", csr_we, 0);
    check("rst_addr", csr_address, 0);
    check("rst_din", csr_din, 0);
    rstn = 1'b1;
    tick();

    run_exc(32'h100, CAUSE_BREAKPOINT, 32'hDEAD, 32'h2003, 32'h2000, 1'b0);
    run_exc(32'h400, CAUSE_MEM_ERR, 32'hFFFF_FFFF, 32'h0, 32'h80, 1'b0);
    run_exc(32'h200, CAUSE_DIV_ZERO, 32'h0, 32'h3001, 32'h3000, 1'b1);

    mepc_val = 32'h104;
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
`ifdef TRAP_MRET_EN
    check("mret_addr0", csr_address, 32'h341);
    check("mret_we0", csr_we, 0);
    check("mret_busy0", busy, 1);
    tick();
    check("mret_addr1", csr_address, 32'h341);
    check("mret_redir1", redir_valid, 0);
    tick();
    check("mret_redir", redir_valid, 1);
    check("mret_target", redir_target, 32'h104);
    tick();
    check("mret_ready", exc_ready, 1);
`else
    for (int i = 0; i < 4; i++) begin
      check("mret_off_redir", redir_valid, 0);
      check("mret_off_busy", busy, 0);
      tick();
    end
`endif

    exc_pc = 32'h500; exc_cause = 32'd1; exc_tval = 32'h55; mtvec_val = 32'h1000;
    exc_valid = 1'b1;
    tick();
    exc_valid = 1'b0;
    tick();
    check("rst_mid_we", csr_we, 1);
    check("rst_mid_addr", csr_address, 32'h342);
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_we0", csr_we, 0);
    check("rst_mid_ready", exc_ready, 1);
    check("rst_mid_busy", busy, 0);
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      rstn = 1'b1;
      if (csr_we && csr_address == 32'h343) saw = 1'b1;
    end
    check("rst_mid_no_mtval", saw, 0);

    exc_pc = 32'h600; exc_cause = 32'd2; exc_tval = 32'h66; mtvec_val = 32'h2000;
    exc_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_ready_low", exc_ready, 0);
      tick();
    end
    check("hold_ready_back", exc_ready, 1);
    tick();
    check("hold_second_we", csr_we, 1);
    check("hold_second_addr", csr_address, 32'h341);
    exc_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("hold_final_ready", exc_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
